// File: rtl/mem_ctrl.sv
// Single byte-wide RAM port controller: arbitrates IF and MEM requests, assembles
// little-endian loads byte by byte and serialises stores, pulsing done per request.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_width_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t            r_state;
    logic              r_owner_mem;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len;
    logic [2:0]        r_cnt;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic              r_if_done;
    logic              r_mem_done;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;

    logic [2:0]        w_mem_len;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_wr_byte;

    assign w_mem_len = (mem_width_i == 2'd0) ? 3'd1 :
                       (mem_width_i == 2'd1) ? 3'd2 : 3'd4;
    assign w_addr    = r_base + ADDR_W'(r_cnt);
    // The byte addressed in cycle k-1 arrives in cycle k and lands in byte lane k-1.
    assign w_rd_word = r_buf | (32'(ram_din_i) << {r_cnt - 3'd1, 3'b000});
    assign w_wr_byte = 8'(r_wdata >> {r_cnt[1:0], 3'b000});

    assign if_done_o   = r_if_done;
    assign if_data_o   = r_if_data;
    assign mem_done_o  = r_mem_done;
    assign mem_rdata_o = r_mem_rdata;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ram_addr_o = '0;
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'd0;
        case (r_state)
            S_RD: if (r_cnt < r_len) ram_addr_o = w_addr;
            S_WR: begin
                ram_addr_o = w_addr;
                ram_wr_o   = 1'b1;
                ram_dout_o = w_wr_byte;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_mem <= 1'b0;
            r_base      <= '0;
            r_len       <= 3'd0;
            r_cnt       <= 3'd0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req_i || if_req_i) begin
                        r_cnt       <= 3'd0;
                        r_buf       <= '0;
                        r_owner_mem <= mem_req_i;
                        if (mem_req_i) begin
                            r_base  <= mem_addr_i;
                            r_len   <= w_mem_len;
                            r_wdata <= mem_wdata_i;
                            r_state <= mem_we_i ? S_WR : S_RD;
                        end else begin
                            r_base  <= if_addr_i;
                            r_len   <= 3'd4;
                            r_wdata <= '0;
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt != 3'd0) r_buf <= w_rd_word;
                    if (r_cnt == r_len) begin
                        r_state <= S_DONE;
                        if (r_owner_mem) begin
                            r_mem_done  <= 1'b1;
                            r_mem_rdata <= w_rd_word;
                        end else begin
                            r_if_done <= 1'b1;
                            r_if_data <= w_rd_word;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_WR: begin
                    if (r_cnt == r_len - 3'd1) begin
                        r_state    <= S_DONE;
                        r_mem_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_if_done  <= 1'b0;
                    r_mem_done <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: requester tasks push expected results computed from a
// byte-array reference memory; a negedge monitor pops and compares on every done/write.
module tb_mem_ctrl;
    localparam int ADDR_W = 17;
    localparam int MSIZE  = 1 << ADDR_W;

    logic              clk, rst;
    logic              if_req_i, if_done_o;
    logic [ADDR_W-1:0] if_addr_i;
    logic [31:0]       if_data_o;
    logic              mem_req_i, mem_we_i, mem_done_o;
    logic [1:0]        mem_width_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i, mem_rdata_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o, ram_din_i;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_data_o(if_data_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_width_i(mem_width_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic st; logic [31:0] d; } mexp_t;

    wr_t         wr_q[$];
    logic [31:0] if_q[$];
    mexp_t       mem_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] seed;
    logic [7:0]  ref_mem [0:MSIZE-1];
    logic [7:0]  ram     [0:MSIZE-1];
    bit          wrote   [0:MSIZE-1];
    logic [31:0] last_if, last_mem;
    logic        mem_known;

    function automatic logic [7:0] init_byte(input logic [ADDR_W-1:0] a);
        logic [31:0] h;
        h = ({15'd0, a} * 32'h9E3779B1) ^ seed;
        return h[23:16];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous byte RAM: read data valid the cycle after the address.
    always @(posedge clk) begin
        ram_din_i <= wrote[ram_addr_o] ? ram[ram_addr_o] : init_byte(ram_addr_o);
        if (ram_wr_o) begin
            ram[ram_addr_o]   <= ram_dout_o;
            wrote[ram_addr_o] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        wr_t   w;
        mexp_t m;
        logic [31:0] e;
        if (ram_wr_o) begin
            check("write_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("write_addr", 32'(ram_addr_o), 32'(w.a));
                check("write_byte", 32'(ram_dout_o), 32'(w.d));
            end
        end
        if (if_done_o) begin
            check("if_done_expected", 32'(if_q.size() != 0), 32'd1);
            check("done_overlap", 32'(mem_done_o), 32'd0);
            if (mem_known) check("mem_rdata_hold", mem_rdata_o, last_mem);
            if (if_q.size() != 0) begin
                e = if_q.pop_front();
                check("if_data", if_data_o, e);
                last_if = e;
            end
        end
        if (mem_done_o) begin
            check("mem_done_expected", 32'(mem_q.size() != 0), 32'd1);
            check("if_data_hold", if_data_o, last_if);
            if (mem_q.size() != 0) begin
                m = mem_q.pop_front();
                if (!m.st) begin
                    check("mem_rdata", mem_rdata_o, m.d);
                    last_mem  = m.d;
                    mem_known = 1'b1;
                end else begin
                    mem_known = 1'b0;
                end
            end
        end
        if (rst) begin
            last_if   = '0;
            last_mem  = '0;
            mem_known = 1'b1;
        end
    end

    task automatic mem_op(input logic we, input logic [1:0] wd_w, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input bit scr, output int lat);
        int n;
        logic [31:0] e;
        logic [ADDR_W-1:0] ai;
        @(negedge clk);
        n = (wd_w == 2'd0) ? 1 : (wd_w == 2'd1) ? 2 : 4;
        e = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + ADDR_W'(i);
            if (we) begin
                wr_q.push_back('{a: ai, d: wd[8*i +: 8]});
                ref_mem[ai] = wd[8*i +: 8];
            end else begin
                e = e | (32'(ref_mem[ai]) << (8 * i));
            end
        end
        mem_q.push_back('{st: we, d: e});
        mem_we_i = we; mem_width_i = wd_w; mem_addr_i = a; mem_wdata_i = wd; mem_req_i = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (scr && lat == 1) begin
                mem_addr_i  = ADDR_W'($urandom);
                mem_wdata_i = $urandom;
                mem_width_i = 2'($urandom);
                mem_we_i    = 1'($urandom);
            end
        end while (!mem_done_o && lat < 200);
        check("mem_done_seen", 32'(mem_done_o), 32'd1);
        @(posedge clk);
        #1 mem_req_i = 1'b0;
    endtask

    task automatic if_fetch(input logic [ADDR_W-1:0] a, input bit scr, output int lat);
        logic [31:0] e;
        @(negedge clk);
        e = '0;
        for (int i = 0; i < 4; i++) e = e | (32'(ref_mem[a + ADDR_W'(i)]) << (8 * i));
        if_q.push_back(e);
        if_addr_i = a; if_req_i = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (scr && lat == 1) if_addr_i = ADDR_W'($urandom);
        end while (!if_done_o && lat < 200);
        check("if_done_seen", 32'(if_done_o), 32'd1);
        @(posedge clk);
        #1 if_req_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_done"},   32'(if_done_o),  32'd0);
        check({tag, "_mem_done"},  32'(mem_done_o), 32'd0);
        check({tag, "_if_data"},   if_data_o,       32'd0);
        check({tag, "_mem_rdata"}, mem_rdata_o,     32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr_o), 32'd0);
        check({tag, "_ram_wr"},    32'(ram_wr_o),   32'd0);
        check({tag, "_ram_dout"},  32'(ram_dout_o), 32'd0);
    endtask

    initial begin
        int lat, lat2;
        seed = $urandom;
        for (int i = 0; i < MSIZE; i++) ref_mem[i] = init_byte(ADDR_W'(i));
        if_req_i = 0; if_addr_i = '0;
        mem_req_i = 0; mem_we_i = 0; mem_width_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single-byte store: one write strobe, done the following cycle.
        mem_op(1'b1, 2'd0, 17'h00020, 32'hAABBCCDD, 1'b1, lat);
        check("store_byte_latency", lat, 2);

        // Word fetch of 11,22,33,44 at 0x100.
        mem_op(1'b1, 2'd2, 17'h00100, 32'h44332211, 1'b0, lat);
        check("store_word_latency", lat, 5);
        if_fetch(17'h00100, 1'b1, lat);
        check("if_fetch_latency", lat, 6);

        // Halfword load wrapping the top of the address space.
        mem_op(1'b1, 2'd0, 17'h1FFFF, 32'h000000B0, 1'b0, lat);
        mem_op(1'b1, 2'd0, 17'h00000, 32'h000000B1, 1'b0, lat);
        mem_op(1'b0, 2'd1, 17'h1FFFF, 32'h0, 1'b1, lat);
        check("load_half_latency", lat, 4);
        mem_op(1'b0, 2'd0, 17'h00020, 32'h0, 1'b0, lat);

        // Simultaneous requests: MEM first, IF accepted once the controller is idle again.
        fork
            mem_op(1'b0, 2'd2, 17'h10040, 32'h0, 1'b0, lat);
            if_fetch(17'h00200, 1'b0, lat2);
        join
        check("arb_mem_latency", lat, 6);
        check("arb_if_latency", lat2, 13);

        // Reset in the cycle the second byte of a word store is being written.
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            wr_q.push_back('{a: 17'h10100 + ADDR_W'(i), d: 8'(32'hCAFEF00D >> (8 * i))});
            ref_mem[17'h10100 + ADDR_W'(i)] = 8'(32'hCAFEF00D >> (8 * i));
        end
        mem_we_i = 1'b1; mem_width_i = 2'd2; mem_addr_i = 17'h10100; mem_wdata_i = 32'hCAFEF00D;
        mem_req_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_req_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        mem_op(1'b0, 2'd2, 17'h10100, 32'h0, 1'b0, lat);
        check("post_reset_latency", lat, 6);

        // Randomized concurrent traffic; MEM stores stay clear of the IF fetch region.
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    int l;
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                    if_fetch(ADDR_W'($urandom_range(32'h0FFF0, 0)), 1'b0, l);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    int l;
                    logic we;
                    repeat ($urandom_range(4, 1)) @(negedge clk);
                    we = 1'($urandom);
                    if (we)
                        mem_op(1'b1, 2'($urandom), ADDR_W'($urandom_range(32'h1FFFC, 32'h10000)),
                               $urandom, 1'b0, l);
                    else
                        mem_op(1'b0, 2'($urandom), ADDR_W'($urandom_range(32'h1FFFF, 32'h10000)),
                               32'h0, 1'b0, l);
                end
            end
        join

        repeat (10) @(negedge clk);
        check("if_queue_drained", if_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        check("write_queue_drained", wr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
